// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - two-master arbiter/sequencer in front of the single-port SRAM controller
//
// Shares one SRAM controller between the instruction-fetch port (IF, read only)
// and the data port (MEM, read/write with byte mask). One request is latched at
// a time, the controller strobe is held until ctl_ack (or the watchdog fires),
// and the result is returned to the owner with a one-cycle ack.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                IF request, held with its address until if_ack
//   if_rdata/if_ack               IF read data, qualified by the one-cycle if_ack
//   mem_req/we/addr/wdata/mask    MEM request and fields, held until mem_ack
//   mem_rdata/mem_ack             MEM read data, qualified by the one-cycle mem_ack
//   ctl_read/ctl_write            controller strobes (never both high)
//   ctl_addr/wdata/mask           latched transaction fields to the controller
//   ctl_rdata/ctl_ack             controller read data and completion pulse
//   timeout_err                   one-cycle pulse, coincident with the ack of an aborted transaction
module sram_bus_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 32,
  parameter int MASK_W       = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [MASK_W-1:0] mem_mask,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              ctl_read,
  output logic              ctl_write,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  output logic [MASK_W-1:0] ctl_mask,
  input  logic [DATA_W-1:0] ctl_rdata,
  input  logic              ctl_ack,
  output logic              timeout_err
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [7:0]      WD_MAX     = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_MEM, RESP} state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   starve_cnt;
  logic [7:0]        wd_cnt;
  logic              pick_if, pick_mem, done_ack, done_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pick_if  = 1'b0;
    pick_mem = 1'b0;
    done_ack = 1'b0;
    done_to  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // MEM wins a tie unless IF has been passed over STARVE_LIMIT times
        if (if_req && (!mem_req || starve_cnt == STARVE_MAX)) begin
          pick_if = 1'b1;
          state_d = GRANT_IF;
        end else if (mem_req) begin
          pick_mem = 1'b1;
          state_d  = GRANT_MEM;
        end
      end
      GRANT_IF, GRANT_MEM: begin
        // ack takes priority over a watchdog expiry in the same cycle
        if (ctl_ack) begin
          done_ack = 1'b1;
          state_d  = RESP;
        end else if (wd_cnt == WD_MAX) begin
          done_to = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_read    <= 1'b0;
      ctl_write   <= 1'b0;
      ctl_addr    <= '0;
      ctl_wdata   <= '0;
      ctl_mask    <= '0;
      if_ack      <= 1'b0;
      mem_ack     <= 1'b0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      timeout_err <= 1'b0;
      starve_cnt  <= '0;
      wd_cnt      <= '0;
    end else begin
      if_ack      <= 1'b0;
      mem_ack     <= 1'b0;
      timeout_err <= 1'b0;

      // wd_cnt holds the number of the current strobe cycle, so the strobe
      // stays up for exactly TIMEOUT cycles when the controller never answers
      if (pick_if) begin
        ctl_read   <= 1'b1;
        ctl_addr   <= if_addr;
        ctl_wdata  <= '0;
        ctl_mask   <= '1;
        starve_cnt <= '0;
        wd_cnt     <= 8'd1;
      end else if (pick_mem) begin
        ctl_read   <= ~mem_we;
        ctl_write  <= mem_we;
        ctl_addr   <= mem_addr;
        ctl_wdata  <= mem_we ? mem_wdata : '0;
        ctl_mask   <= mem_we ? mem_mask : '1;
        if (if_req)
          starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
        else
          starve_cnt <= '0;
        wd_cnt     <= 8'd1;
      end else if (state_q == IDLE) begin
        // idle with no grant means nobody requested, so IF is not waiting
        starve_cnt <= '0;
      end

      if (done_ack || done_to) begin
        ctl_read    <= 1'b0;
        ctl_write   <= 1'b0;
        wd_cnt      <= '0;
        timeout_err <= done_to;
        if (state_q == GRANT_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= done_ack ? ctl_rdata : '0;
        end else begin
          mem_ack   <= 1'b1;
          mem_rdata <= done_ack ? ctl_rdata : '0;
        end
      end else if (state_q == GRANT_IF || state_q == GRANT_MEM) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
    end
  end

endmodule
